// File: rtl/ddram_wb_pkg.sv
// Shared types for the DDRAM posted-write buffer.
// Build option: DDRAM_WB_MERGE_EN enables merging a write into the FIFO tail entry.
package ddram_wb_pkg;

  localparam int unsigned ENTRY_AW  = 32;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);

  // Entry address is stored zero-extended; ADDRBITS+1 must not exceed ENTRY_AW.
  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [63:0]         data;
    logic [7:0]          be;
  } wb_entry_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DRAIN,
    R_ISSUE,
    R_WAIT
  } rd_state_t;

  function automatic logic [63:0] be_merge(input logic [63:0] old_d,
                                           input logic [63:0] new_d,
                                           input logic [7:0]  be);
    logic [63:0] r;
    r = old_d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ddram_wb_fifo.sv
// Synchronous FIFO of write entries with head/tail read ports.
// Build option: DDRAM_WB_MERGE_EN adds a byte-merge port onto the tail entry.
module ddram_wb_fifo
  import ddram_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output wb_entry_t                tail,
`ifdef DDRAM_WB_MERGE_EN
  input  logic                     merge,
  input  logic [63:0]              merge_data,
  input  logic [7:0]               merge_be,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   tail_ptr;

  assign tail_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
`ifdef DDRAM_WB_MERGE_EN
    else if (merge) begin
      mem[tail_ptr].data <= be_merge(mem[tail_ptr].data, merge_data, merge_be);
      mem[tail_ptr].be   <= mem[tail_ptr].be | merge_be;
    end
`endif
  end

endmodule

// File: rtl/ddram_write_buffer.sv
// Posted-write buffer between the L2 DDRAM master port and the DDR3 controller; reads wait for all writes.
// Build option: DDRAM_WB_MERGE_EN merges same-address writes into the tail entry.
module ddram_write_buffer
  import ddram_wb_pkg::*;
#(
  parameter int unsigned ADDRBITS = 24,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDRBITS:0]   S_ADDR,
  input  logic [63:0]         S_DIN,
  input  logic [7:0]          S_BE,
  input  logic [7:0]          S_BURSTCNT,
  input  logic                S_RD,
  input  logic                S_WE,
  output logic                S_BUSY,
  output logic [63:0]         S_DOUT,
  output logic                S_DOUT_READY,
  output logic [ADDRBITS:0]   DDRAM_ADDR,
  output logic [63:0]         DDRAM_DIN,
  output logic [7:0]          DDRAM_BE,
  output logic [7:0]          DDRAM_BURSTCNT,
  output logic                DDRAM_RD,
  output logic                DDRAM_WE,
  input  logic                DDRAM_BUSY,
  input  logic [63:0]         DDRAM_DOUT,
  input  logic                DDRAM_DOUT_READY,
  output logic                WB_EMPTY
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rd_state_t          rd_state;
  logic [ADDRBITS:0]  rd_addr;
  logic [7:0]         rd_len;
  logic [7:0]         beats_left;
  logic [CW-1:0]      count;
  wb_entry_t          head;
  wb_entry_t          tail;
  wb_entry_t          push_entry;
  logic               full, empty, out_free, pop, push, rd_acc, we_acc;
  logic               unused_bits;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign out_free = ~DDRAM_WE | ~DDRAM_BUSY;
  assign pop      = out_free & ~empty;
  assign rd_acc   = S_RD & ~S_BUSY;
  assign we_acc   = S_WE & ~S_RD & ~S_BUSY;
  assign WB_EMPTY = empty & ~DDRAM_WE;

  assign push_entry  = '{addr: ENTRY_AW'(S_ADDR), data: S_DIN, be: S_BE};
  assign unused_bits = &{1'b0, head, tail};

`ifdef DDRAM_WB_MERGE_EN
  logic addr_match, merge;
  assign addr_match = (tail.addr == ENTRY_AW'(S_ADDR));
  // Busy ignores the pop term: at full the tail can never be the entry being popped.
  assign S_BUSY = (full & ~addr_match) | (rd_state != R_IDLE);
  assign merge  = we_acc & addr_match & ~empty & ~((count == CW'(1)) & pop);
  assign push   = we_acc & ~merge;
`else
  assign S_BUSY = full | (rd_state != R_IDLE);
  assign push   = we_acc;
`endif

  ddram_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .reset      (RESET),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .tail       (tail),
`ifdef DDRAM_WB_MERGE_EN
    .merge      (merge),
    .merge_data (S_DIN),
    .merge_be   (S_BE),
`endif
    .count      (count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_state       <= R_IDLE;
      rd_addr        <= '0;
      rd_len         <= 8'd1;
      beats_left     <= '0;
      S_DOUT         <= '0;
      S_DOUT_READY   <= 1'b0;
      DDRAM_ADDR     <= '0;
      DDRAM_DIN      <= '0;
      DDRAM_BE       <= '0;
      DDRAM_BURSTCNT <= 8'd1;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
    end else begin
      S_DOUT_READY <= 1'b0;

      if (pop) begin
        DDRAM_ADDR     <= head.addr[ADDRBITS:0];
        DDRAM_DIN      <= head.data;
        DDRAM_BE       <= head.be;
        DDRAM_BURSTCNT <= 8'd1;
        DDRAM_WE       <= 1'b1;
      end else if (out_free) begin
        DDRAM_WE <= 1'b0;
      end

      // The read request shares the output register; it is only loaded when no pop can occur.
      case (rd_state)
        R_IDLE: begin
          if (rd_acc) begin
            rd_addr  <= S_ADDR;
            rd_len   <= (S_BURSTCNT == '0) ? 8'd1 : S_BURSTCNT;
            rd_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (empty && !DDRAM_WE) begin
            DDRAM_RD       <= 1'b1;
            DDRAM_ADDR     <= rd_addr;
            DDRAM_BE       <= '0;
            DDRAM_BURSTCNT <= rd_len;
            rd_state       <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD   <= 1'b0;
            beats_left <= rd_len;
            rd_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            S_DOUT       <= DDRAM_DOUT;
            S_DOUT_READY <= 1'b1;
            beats_left   <= beats_left - 1'b1;
            if (beats_left == 8'd1) rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_write_buffer.sv
// Scoreboard bench for ddram_write_buffer: directed scenarios plus random traffic against a queue model.
// Build option: DDRAM_WB_MERGE_EN switches the expected result of the merge scenario.
module tb_ddram_write_buffer;

  localparam int ADDRBITS = 24;
  localparam int DEPTH    = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ADDRBITS:0] S_ADDR;
  logic [63:0]       S_DIN;
  logic [7:0]        S_BE;
  logic [7:0]        S_BURSTCNT;
  logic              S_RD, S_WE;
  logic              S_BUSY;
  logic [63:0]       S_DOUT;
  logic              S_DOUT_READY;
  logic [ADDRBITS:0] DDRAM_ADDR;
  logic [63:0]       DDRAM_DIN;
  logic [7:0]        DDRAM_BE;
  logic [7:0]        DDRAM_BURSTCNT;
  logic              DDRAM_RD, DDRAM_WE;
  logic              DDRAM_BUSY;
  logic [63:0]       DDRAM_DOUT;
  logic              DDRAM_DOUT_READY;
  logic              WB_EMPTY;

  ddram_write_buffer #(.ADDRBITS(ADDRBITS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_ADDR(S_ADDR), .S_DIN(S_DIN), .S_BE(S_BE), .S_BURSTCNT(S_BURSTCNT),
    .S_RD(S_RD), .S_WE(S_WE), .S_BUSY(S_BUSY), .S_DOUT(S_DOUT), .S_DOUT_READY(S_DOUT_READY),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .WB_EMPTY(WB_EMPTY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [ADDRBITS:0] addr; logic [63:0] data; logic [7:0] be; } wr_t;
  typedef struct { logic [ADDRBITS:0] addr; logic [7:0] len; } rd_t;
  typedef struct { logic [63:0] data; int cyc; } beat_t;

  wr_t   wq[$];
  rd_t   rq[$];
  beat_t bq[$];
  int    wr_cycles[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_mode  = 0;
  int beats_owed = 0;
  bit resp_hold  = 1'b0;
  bit stray      = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model: back-pressure per busy_mode, returns read beats with random gaps.
  initial begin
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) beats_owed = 0;
      else if (DDRAM_RD && !DDRAM_BUSY) beats_owed += int'(DDRAM_BURSTCNT);
      @(posedge CLK); #2;
      case (busy_mode)
        0:       DDRAM_BUSY = 1'b0;
        1:       DDRAM_BUSY = 1'b1;
        default: DDRAM_BUSY = ($urandom_range(0, 3) == 0);
      endcase
      DDRAM_DOUT_READY = 1'b0;
      if (stray) begin
        DDRAM_DOUT = {$urandom, $urandom};
        DDRAM_DOUT_READY = 1'b1;
      end else if (beats_owed > 0 && !resp_hold && $urandom_range(0, 3) != 0) begin
        DDRAM_DOUT = {$urandom, $urandom};
        DDRAM_DOUT_READY = 1'b1;
        beats_owed--;
        bq.push_back('{DDRAM_DOUT, cyc});
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a downstream request or read data.
  logic              prev_stall = 1'b0;
  logic [ADDRBITS:0] pa;
  logic [63:0]       pd;
  logic [7:0]        pb;
  int                mon_beats = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        mon_beats = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (S_RD && S_WE) $display("note: illegal S_RD+S_WE pair presented at t=%0t", $time);
      if (DDRAM_RD) chk("rd_we_exclusive", DDRAM_WE, 1'b0);
      if (prev_stall) chk("we_hold_stable", {DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE}, {1'b1, pa, pd, pb});
      prev_stall = DDRAM_WE && DDRAM_BUSY;
      pa = DDRAM_ADDR; pd = DDRAM_DIN; pb = DDRAM_BE;

      if (DDRAM_WE && !DDRAM_BUSY) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", DDRAM_ADDR, DDRAM_DIN);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("ddram_write", {DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT}, {e.addr, e.data, e.be, 8'd1});
          wr_cycles.push_back(cyc);
        end
      end

      if (DDRAM_RD && !DDRAM_BUSY) begin
        chk("rd_after_writes", wq.size(), 0);
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got addr %0h, required no read", DDRAM_ADDR);
        end else begin
          rd_t r;
          r = rq.pop_front();
          chk("ddram_read", {DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_BE}, {r.addr, r.len, 8'h00});
          mon_beats = int'(r.len);
        end
      end

      if (S_DOUT_READY) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rdata: got %0h, required none", S_DOUT);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("rdata", S_DOUT, b.data);
          chk("rdata_latency", cyc, b.cyc + 1);
          mon_beats--;
          chk("busy_vs_beats", S_BUSY, (mon_beats == 0) ? 1'b0 : 1'b1);
        end
      end
    end
  end

  task automatic wr(input logic [ADDRBITS:0] a, input logic [63:0] d, input logic [7:0] be,
                    input bit exp_push, output int waits);
    waits = 0;
    S_ADDR = a; S_DIN = d; S_BE = be; S_BURSTCNT = 8'd1; S_WE = 1'b1;
    forever begin
      @(negedge CLK);
      if (!S_BUSY) break;
      waits++;
      if (waits > 2000) begin
        total++; bad++;
        $display("FAIL wr_timeout: got S_BUSY stuck 1, required acceptance of addr %0h", a);
        break;
      end
    end
    if (exp_push && waits <= 2000) wq.push_back('{a, d, be});
    @(posedge CLK); #1;
    S_WE = 1'b0;
  endtask

  task automatic rd(input logic [ADDRBITS:0] a, input logic [7:0] bc, input bit also_we);
    int waits = 0;
    S_ADDR = a; S_BURSTCNT = bc; S_RD = 1'b1; S_WE = also_we;
    S_DIN = {$urandom, $urandom}; S_BE = 8'hFF;
    forever begin
      @(negedge CLK);
      if (!S_BUSY) break;
      waits++;
      if (waits > 2000) begin
        total++; bad++;
        $display("FAIL rd_timeout: got S_BUSY stuck 1, required acceptance of read %0h", a);
        break;
      end
    end
    if (waits <= 2000) rq.push_back('{a, (bc == 8'd0) ? 8'd1 : bc});
    @(posedge CLK); #1;
    S_RD = 1'b0; S_WE = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge CLK);
      if (WB_EMPTY && !S_BUSY && wq.size() == 0 && rq.size() == 0 && bq.size() == 0 && beats_owed == 0)
        break;
    end
    if (k == 5000) begin
      total++; bad++;
      $display("FAIL %s_idle_timeout: got busy/pending traffic, required idle", name);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int w0, w1, w2, ws;
    logic [63:0]       da, db;
    logic [ADDRBITS:0] a, last_a;

    RESET = 1'b1; S_ADDR = '0; S_DIN = '0; S_BE = '0; S_BURSTCNT = 8'd1; S_RD = 1'b0; S_WE = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_s_busy", S_BUSY, 1'b0);
    chk("rst_s_dout_ready", S_DOUT_READY, 1'b0);
    chk("rst_s_dout", S_DOUT, 64'd0);
    chk("rst_ddram_rd", DDRAM_RD, 1'b0);
    chk("rst_ddram_we", DDRAM_WE, 1'b0);
    chk("rst_burstcnt", DDRAM_BURSTCNT, 8'd1);
    chk("rst_wb_empty", WB_EMPTY, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Back-to-back writes with a free controller.
    busy_mode = 0;
    wr_cycles.delete();
    wr(25'h10, 64'h1111_0000_AAAA_0010, 8'hFF, 1'b1, w0);
    wr(25'h11, 64'h2222_0000_BBBB_0011, 8'h3C, 1'b1, w1);
    wr(25'h12, 64'h3333_0000_CCCC_0012, 8'h81, 1'b1, w2);
    chk("t2_no_stall", w0 + w1 + w2, 0);
    wait_idle("t2");
    chk("t2_write_count", wr_cycles.size(), 3);
    if (wr_cycles.size() == 3) chk("t2_consecutive", wr_cycles[2] - wr_cycles[0], 2);

    // Fill with controller stalled: output register plus DEPTH FIFO entries.
    busy_mode = 1;
    ws = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(25'h30 + 25'(i), {$urandom, $urandom}, 8'($urandom), 1'b1, w0);
      ws += w0;
    end
    chk("t3_fill_no_stall", ws, 0);
    da = {$urandom, $urandom};
    S_ADDR = 25'h3A; S_DIN = da; S_BE = 8'hA5; S_WE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t3_full_busy", S_BUSY, 1'b1);
    end
    @(posedge CLK); #1;
    busy_mode = 0;
    @(negedge CLK);
    chk("t3_busy_before_pop", S_BUSY, 1'b1);
    @(negedge CLK);
    chk("t3_busy_after_pop", S_BUSY, 1'b0);
    wq.push_back('{25'h3A, da, 8'hA5});
    @(posedge CLK); #1;
    S_WE = 1'b0;
    wait_idle("t3");

    // Read ordered behind buffered writes.
    busy_mode = 1;
    wr(25'hA1, {$urandom, $urandom}, 8'hFF, 1'b1, w0);
    wr(25'hA2, {$urandom, $urandom}, 8'h0F, 1'b1, w0);
    rd(25'h40, 8'd8, 1'b0);
    repeat (4) @(posedge CLK);
    #1 busy_mode = 0;
    wait_idle("t4");

    // Same-address writes while stalled; a filler occupies the output register first.
    busy_mode = 1;
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    wr(25'h1F, {$urandom, $urandom}, 8'hFF, 1'b1, w0);
`ifdef DDRAM_WB_MERGE_EN
    wr(25'h20, da, 8'h0F, 1'b0, w0);
    wr(25'h20, db, 8'hF0, 1'b0, w1);
    wq.push_back('{25'h20, {db[63:32], da[31:0]}, 8'hFF});
`else
    wr(25'h20, da, 8'h0F, 1'b1, w0);
    wr(25'h20, db, 8'hF0, 1'b1, w1);
`endif
    chk("t5_no_stall", w0 + w1, 0);
    repeat (3) @(posedge CLK);
    #1 busy_mode = 0;
    wait_idle("t5");

    // Illegal simultaneous strobes: read wins, write dropped.
    busy_mode = 0;
    rd(25'h55, 8'd2, 1'b1);
    @(negedge CLK);
    chk("t6_no_push", WB_EMPTY, 1'b1);
    wait_idle("t6");

    // Random mixed traffic with random back-pressure.
    busy_mode = 2;
    last_a = 25'h20;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rd(25'($urandom), 8'($urandom_range(0, 8)), 1'b0);
      end else begin
        a = 25'($urandom);
        if (a == last_a) a = a + 1'b1;
        last_a = a;
        wr(a, {$urandom, $urandom}, 8'($urandom), 1'b1, w0);
      end
    end
    busy_mode = 0;
    wait_idle("rand");

    // Reset while waiting for read data; later data pulses must be ignored.
    resp_hold = 1'b1;
    rd(25'h80, 8'd8, 1'b0);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(negedge CLK);
        if (rq.size() == 0) break;
      end
      chk("t1b_read_issued", rq.size(), 0);
    end
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    wq.delete(); rq.delete(); bq.delete();
    resp_hold = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t1b_no_forward", S_DOUT_READY, 1'b0);
      chk("t1b_fsm_idle", S_BUSY, 1'b0);
    end
    @(posedge CLK); #1;
    stray = 1'b0;
    wait_idle("t1b");

    chk("end_wq_empty", wq.size(), 0);
    chk("end_rq_empty", rq.size(), 0);
    chk("end_bq_empty", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required $finish");
    $fatal(1, "global timeout");
  end

endmodule
